// File: rtl/pwm_dac_out_if.sv
// Sample handshake between the audio mixer (master) and the PWM output stage (slave).
interface pwm_dac_out_if #(
   parameter int CNT_W = 8
);
   logic [CNT_W-1:0] sample;
   logic             sample_valid;
   logic             sample_ready;

   modport master (
      output sample,
      output sample_valid,
      input  sample_ready
   );

   modport slave (
      input  sample,
      input  sample_valid,
      output sample_ready
   );
endinterface

// File: rtl/pwm_dac_out.sv
// PWM audio output stage: one-entry sample buffer, free-running carrier, duty latched at wrap.
// Optional feature macro: PWM_UNDERRUN_CNT_EN adds a saturating underrun_cnt output.
module pwm_dac_out #(
   parameter int               CNT_W     = 8,
   parameter logic [CNT_W-1:0] IDLE_DUTY = {CNT_W{1'b0}}
) (
   input  logic           clk,
   input  logic           nRst,
   input  logic           en,
   pwm_dac_out_if.slave   smp,
   output logic           sample_req,
   output logic           pwm_out,
   output logic           underrun
`ifdef PWM_UNDERRUN_CNT_EN
   ,
   output logic [7:0]     underrun_cnt
`endif
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] duty_q, duty_d;
   logic [CNT_W-1:0] hold_q, hold_d;
   logic             hold_full_q, hold_full_d;
   logic             pwm_q, pwm_d;
   logic             req_q, req_d;
   logic             und_q, und_d;
   logic             wrap_s;
   logic             xfer_s;

`ifdef PWM_UNDERRUN_CNT_EN
   logic [7:0]       ucnt_q, ucnt_d;
`endif

   assign wrap_s           = en && (cnt_q == CNT_MAX);
   assign xfer_s           = smp.sample_valid && !hold_full_q;
   assign smp.sample_ready = ~hold_full_q;

   // Next-state logic: carrier advance, buffer fill/drain, duty swap only at wrap.
   always_comb begin
      cnt_d       = cnt_q;
      duty_d      = duty_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      if (en) begin
         cnt_d = cnt_q + CNT_ONE;
      end else begin
         cnt_d = cnt_q;
      end
      if (xfer_s) begin
         hold_d = smp.sample;
      end else begin
         hold_d = hold_q;
      end
      // A transfer needs an empty buffer, so it can never collide with a drain.
      if (wrap_s && hold_full_q) begin
         duty_d      = hold_q;
         hold_full_d = 1'b0;
      end else if (xfer_s) begin
         hold_full_d = 1'b1;
      end else begin
         hold_full_d = hold_full_q;
      end
      pwm_d = en && (cnt_q < duty_q);
      req_d = wrap_s;
      und_d = wrap_s && !hold_full_q;
   end

`ifdef PWM_UNDERRUN_CNT_EN
   // Saturating underrun counter, advances together with the registered pulse.
   always_comb begin
      if (und_d && (ucnt_q != 8'hFF)) begin
         ucnt_d = ucnt_q + 8'd1;
      end else begin
         ucnt_d = ucnt_q;
      end
   end
`endif

   // State and output registers.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         cnt_q       <= {CNT_W{1'b0}};
         duty_q      <= IDLE_DUTY;
         hold_q      <= {CNT_W{1'b0}};
         hold_full_q <= 1'b0;
         pwm_q       <= 1'b0;
         req_q       <= 1'b0;
         und_q       <= 1'b0;
`ifdef PWM_UNDERRUN_CNT_EN
         ucnt_q      <= 8'd0;
`endif
      end else begin
         cnt_q       <= cnt_d;
         duty_q      <= duty_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         pwm_q       <= pwm_d;
         req_q       <= req_d;
         und_q       <= und_d;
`ifdef PWM_UNDERRUN_CNT_EN
         ucnt_q      <= ucnt_d;
`endif
      end
   end

   assign pwm_out    = pwm_q;
   assign sample_req = req_q;
   assign underrun   = und_q;
`ifdef PWM_UNDERRUN_CNT_EN
   assign underrun_cnt = ucnt_q;
`endif

endmodule

// File: tb/tb_pwm_dac_out.sv
// Self-checking bench for pwm_dac_out: directed test-plan scenarios plus randomized traffic
// compared cycle by cycle against a period/queue-based reference model.
module tb_pwm_dac_out;

   logic       clk = 1'b0;
   logic       nRst;
   logic       en;
   logic       sample_req;
   logic       pwm_out;
   logic       underrun;
`ifdef PWM_UNDERRUN_CNT_EN
   logic [7:0] underrun_cnt;
`endif

   pwm_dac_out_if #(.CNT_W(8)) smp_if ();

   pwm_dac_out #(
      .CNT_W     (8),
      .IDLE_DUTY (8'd0)
   ) dut (
      .clk          (clk),
      .nRst         (nRst),
      .en           (en),
      .smp          (smp_if),
      .sample_req   (sample_req),
      .pwm_out      (pwm_out),
      .underrun     (underrun)
`ifdef PWM_UNDERRUN_CNT_EN
      ,
      .underrun_cnt (underrun_cnt)
`endif
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: position within the 256-cycle period, current duty, buffer as a queue.
   int m_phase;
   int m_duty;
   int m_ucnt;
   int m_buf[$];
   bit m_pwm, m_req, m_und, m_acc;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic model_reset();
      m_phase = 0;
      m_duty  = 0;
      m_ucnt  = 0;
      m_buf.delete();
      m_pwm = 1'b0;
      m_req = 1'b0;
      m_und = 1'b0;
      m_acc = 1'b0;
   endtask

   task automatic model_step(input bit e, input bit v, input int s);
      bit wrapping;
      wrapping = e && (m_phase == 255);
      m_acc    = v && (m_buf.size() == 0);
      m_pwm    = e && (m_phase < m_duty);
      m_req    = wrapping;
      m_und    = wrapping && (m_buf.size() == 0);
      if (m_und && m_ucnt < 255) m_ucnt++;
      if (wrapping && m_buf.size() != 0) m_duty = m_buf.pop_front();
      if (m_acc) m_buf.push_back(s);
      if (e) m_phase = (m_phase + 1) % 256;
   endtask

   task automatic compare_outs();
      check_eq("pwm_out", pwm_out, m_pwm);
      check_eq("sample_req", sample_req, m_req);
      check_eq("underrun", underrun, m_und);
      check_eq("sample_ready", smp_if.sample_ready, (m_buf.size() == 0));
`ifdef PWM_UNDERRUN_CNT_EN
      check_eq("underrun_cnt", underrun_cnt, m_ucnt);
`endif
   endtask

   task automatic tick(input bit e, input bit v, input logic [7:0] s);
      en                  = e;
      smp_if.sample_valid = v;
      smp_if.sample       = s;
      @(posedge clk);
      model_step(e, v, int'(s));
      #1;
      compare_outs();
   endtask

   task automatic apply_reset();
      en                  = 1'b0;
      smp_if.sample_valid = 1'b0;
      #2;
      nRst = 1'b0;
      #1;
      model_reset();
      compare_outs();
      #10;
      compare_outs();
      nRst = 1'b1;
   endtask

   task automatic wait_req();
      int n;
      n = 0;
      do begin
         tick(1'b1, 1'b0, 8'd0);
         n++;
      end while (!sample_req && n < 300);
      check_eq("req_seen", sample_req, 1'b1);
   endtask

   task automatic count_high(input string tag, input int exp);
      int hi;
      hi = 0;
      repeat (256) begin
         tick(1'b1, 1'b0, 8'd0);
         if (pwm_out === 1'b1) hi++;
      end
      check_eq(tag, hi, exp);
   endtask

   task automatic push(input logic [7:0] s);
      tick(1'b1, 1'b1, s);
      check_eq("ready_drop", smp_if.sample_ready, 1'b0);
   endtask

   initial begin
      int  unds, reqs, his, n;
      bit  was_ready, was_req, p_valid;
      logic [7:0] p_sample;

      // Reset state.
      nRst = 1'b0;
      en = 1'b0;
      smp_if.sample_valid = 1'b0;
      smp_if.sample = 8'd0;
      model_reset();
      #12;
      compare_outs();
      nRst = 1'b1;

      // No samples: idle duty, underrun and request once per period.
      unds = 0; reqs = 0; his = 0;
      repeat (512) begin
         tick(1'b1, 1'b0, 8'd0);
         if (underrun === 1'b1) unds++;
         if (sample_req === 1'b1) reqs++;
         if (pwm_out === 1'b1) his++;
      end
      check_eq("idle_underruns", unds, 2);
      check_eq("idle_reqs", reqs, 2);
      check_eq("idle_high", his, 0);

      // Mid-scale, then the two extremes in successive periods.
      push(8'd128);
      wait_req();
      count_high("period_128", 128);
      check_eq("ready_back", smp_if.sample_ready, 1'b1);
      push(8'd0);
      wait_req();
      count_high("period_0", 0);
      push(8'd255);
      wait_req();
      count_high("period_255", 255);

      // Push on the exact wrap cycle with an empty buffer.
      n = 0;
      while (m_phase != 255 && n < 300) begin
         tick(1'b1, 1'b0, 8'd0);
         n++;
      end
      tick(1'b1, 1'b1, 8'h40);
      check_eq("wrap_push_und", underrun, 1'b1);
      check_eq("wrap_push_ready", smp_if.sample_ready, 1'b0);
      count_high("wrap_push_old_duty", 255);
      count_high("wrap_push_new_duty", 64);

      // Full buffer with valid held: accepted only the cycle after the wrap.
      push(8'h10);
      n = 0;
      do begin
         was_ready = smp_if.sample_ready;
         was_req   = sample_req;
         tick(1'b1, 1'b1, 8'h20);
         n++;
      end while (!was_ready && n < 300);
      check_eq("hold_accept_after_wrap", was_req, 1'b1);
      wait_req();
      count_high("held_sample_duty", 32);

      // Enable drop mid-period: count frozen, output low.
      wait_req();
      his = 0;
      repeat (5) begin
         tick(1'b1, 1'b0, 8'd0);
         if (pwm_out === 1'b1) his++;
      end
      check_eq("pre_freeze_high", his, 5);
      repeat (10) tick(1'b0, 1'b0, 8'd0);
      check_eq("frozen_pwm", pwm_out, 1'b0);
      n = 0; his = 0;
      do begin
         tick(1'b1, 1'b0, 8'd0);
         n++;
         if (pwm_out === 1'b1) his++;
      end while (!sample_req && n < 300);
      check_eq("resume_len", n, 251);
      check_eq("resume_high", his, 27);

      // Reset mid-pulse with a sample held: both sample and duty are discarded.
      repeat (3) tick(1'b1, 1'b0, 8'd0);
      check_eq("pulse_before_rst", pwm_out, 1'b1);
      push(8'h77);
      apply_reset();
      wait_req();
      count_high("duty_after_rst", 0);

      // Randomized traffic with a well-behaved producer.
      p_valid = 1'b0;
      p_sample = 8'd0;
      for (int i = 0; i < 20000; i++) begin
         if (!p_valid && $urandom_range(0, 3) == 0) begin
            p_valid  = 1'b1;
            p_sample = 8'($urandom_range(0, 255));
         end
         tick(($urandom_range(0, 15) != 0), p_valid, p_sample);
         if (m_acc) p_valid = 1'b0;
         if ($urandom_range(0, 4999) == 0) begin
            apply_reset();
            p_valid = 1'b0;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
